multi_request_unit: RTL and testbench

- Parametrised successor to the single-port request unit.
- Sequences one instruction fetch and then up to NCH data accesses per pipeline step through a single shared memory interface.
- Data channels are served round-robin. A channel requesting both read and write is served write-then-read.
- A hit-timeout watchdog flags stalled memory.
- Sits between the pipeline (PC, per-channel data requests) and the cache/memory controller.

---
 rtl/multi_request_unit.sv | 170 +++++++++++++++++
 tb/tb_multi_request_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_request_unit.sv
// Shared-port request sequencer: one instruction fetch, then up to NCH data accesses per
// pipeline step, served round-robin, with a hit-timeout watchdog.
module multi_request_unit #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned NCH     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     pc,
    input  logic              ihit,
    input  logic [DW-1:0]     instr,
    output logic              iren,
    output logic [AW-1:0]     iaddr,
    output logic [DW-1:0]     instr_q,
    input  logic [NCH-1:0]    ch_rd,
    input  logic [NCH-1:0]    ch_wr,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_done,
    output logic [DW-1:0]     rdata,
    input  logic              dhit,
    input  logic [DW-1:0]     dload,
    output logic              dren,
    output logic              dwen,
    output logic [AW-1:0]     daddr,
    output logic [DW-1:0]     dstore,
    output logic              adv,
    output logic              err
);
    localparam int unsigned   SW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DWRITE = 2'd1;
    localparam logic [1:0] DREAD  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [SW-1:0]  sel_q, sel_d, rr_q, rr_d;
    logic [NCH-1:0] served_q, served_d, wr_done_q, wr_done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  instr_d;

    logic           hit, timeout, complete, adv_c, err_c;
    logic           found_f, found_c;
    logic [SW-1:0]  idx_f, idx_c, ptr_next;
    logic [NCH-1:0] pending, pend_rest, sel_oh, done_c;

    // Returns {found, index} of the first set bit of mask at or after ptr, wrapping at NCH.
    function automatic logic [SW:0] pick(input logic [NCH-1:0] mask, input logic [SW-1:0] ptr);
        logic          found;
        logic [SW-1:0] idx;
        int unsigned   j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            j = (32'(ptr) + k) % NCH;
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = SW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign pending   = (ch_rd | ch_wr) & ~served_q;
    assign sel_oh    = NCH'(1) << sel_q;
    assign pend_rest = pending & ~sel_oh;
    assign ptr_next  = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
    assign {found_f, idx_f} = pick(pending, rr_q);
    assign {found_c, idx_c} = pick(pend_rest, ptr_next);

    // Only the hit relevant to the current phase counts.
    assign hit     = (state_q == FETCH) ? ihit : dhit;
    assign timeout = (TIMEOUT != 0) && !hit && (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        served_d  = served_q;
        wr_done_d = wr_done_q;
        instr_d   = instr_q;
        complete  = 1'b0;
        err_c     = 1'b0;
        done_c    = '0;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    instr_d = instr;
                    if (found_f) begin
                        sel_d   = idx_f;
                        state_d = (ch_wr[idx_f] && !wr_done_q[idx_f]) ? DWRITE : DREAD;
                    end
                end else if (timeout) begin
                    err_c = 1'b1;
                end
            end
            DWRITE, DREAD: begin
                if (dhit) begin
                    if (state_q == DWRITE && ch_rd[sel_q]) begin
                        wr_done_d[sel_q] = 1'b1;
                        state_d          = DREAD;
                    end else begin
                        complete = 1'b1;
                    end
                end else if (timeout) begin
                    served_d = served_q | sel_oh;
                    err_c    = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (complete) begin
            done_c   = sel_oh;
            served_d = served_q | sel_oh;
            rr_d     = ptr_next;
            if (found_c) begin
                sel_d   = idx_c;
                state_d = (ch_wr[idx_c] && !wr_done_q[idx_c]) ? DWRITE : DREAD;
            end else begin
                state_d = FETCH;
            end
        end

        adv_c = (state_d == FETCH) && hit && !timeout;
        if (adv_c) begin
            served_d  = '0;
            wr_done_d = '0;
        end
        cnt_d = (hit || timeout || state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            sel_q     <= '0;
            rr_q      <= '0;
            served_q  <= '0;
            wr_done_q <= '0;
            cnt_q     <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            served_q  <= served_d;
            wr_done_q <= wr_done_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
        end
    end

    // Pulses are suppressed while reset is held so nothing leaks out mid-reset.
    assign iren    = (state_q == FETCH);
    assign iaddr   = iren ? pc : '0;
    assign dwen    = (state_q == DWRITE);
    assign dren    = (state_q == DREAD);
    assign daddr   = (dwen || dren) ? ch_addr[sel_q*AW +: AW] : '0;
    assign dstore  = dwen ? ch_wdata[sel_q*DW +: DW] : '0;
    assign rdata   = (dren && dhit && !rst) ? dload : '0;
    assign ch_done = done_c & {NCH{!rst}};
    assign adv     = adv_c && !rst;
    assign err     = err_c && !rst;
endmodule

// File: tb/tb_multi_request_unit.sv
// Bench for multi_request_unit: directed cases with literal expectations, then random traffic
// checked every cycle against a queue-of-accesses model.
module tb_multi_request_unit;
    localparam int NCH = 2;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, instr, dload;
    logic        ihit, dhit;
    logic [1:0]  ch_rd, ch_wr;
    logic [63:0] ch_addr, ch_wdata;
    logic        iren, dren, dwen, adv, err;
    logic [31:0] iaddr, instr_q, rdata, daddr, dstore;
    logic [1:0]  ch_done;

    int n_tests = 0;
    int n_fail  = 0;

    multi_request_unit #(.AW(32), .DW(32), .NCH(NCH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ihit(ihit), .instr(instr), .iren(iren), .iaddr(iaddr),
        .instr_q(instr_q), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(ch_done), .rdata(rdata), .dhit(dhit), .dload(dload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .adv(adv), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a step is a fetch followed by a queue of accesses (ch*2 + is_write).
    bit          m_fetch;
    logic [1:0]  m_served;
    int          m_rr, m_waitc;
    logic [31:0] m_instr_q;
    int          m_ops[$];
    bit          req_free;

    always @(negedge clk) begin : model_chk
        int         op, c;
        bit         w;
        logic [1:0] pend, e_done;
        bit         e_adv, e_err;
        if (rst) begin
            chk("rst_iren", iren, 1);   chk("rst_iaddr", iaddr, pc);
            chk("rst_dren", dren, 0);   chk("rst_dwen", dwen, 0);
            chk("rst_adv", adv, 0);     chk("rst_err", err, 0);
            chk("rst_done", ch_done, 0); chk("rst_instr_q", instr_q, 0);
            chk("rst_daddr", daddr, 0); chk("rst_dstore", dstore, 0);
            m_fetch = 1; m_served = 0; m_rr = 0; m_waitc = 0; m_instr_q = 0;
            m_ops.delete();
            req_free = 1;
        end else begin
            e_done = 0; e_adv = 0; e_err = 0;
            chk("instr_q", instr_q, m_instr_q);
            if (m_fetch) begin
                chk("iren", iren, 1);   chk("iaddr", iaddr, pc);
                chk("dren", dren, 0);   chk("dwen", dwen, 0);
                chk("daddr", daddr, 0); chk("dstore", dstore, 0);
                if (ihit) begin
                    m_instr_q = instr;
                    m_waitc   = 0;
                    pend      = (ch_rd | ch_wr) & ~m_served;
                    if (pend == 0) begin
                        e_adv    = 1;
                        m_served = 0;
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            c = (m_rr + k) % NCH;
                            if (pend[c]) begin
                                if (ch_wr[c]) m_ops.push_back(c * 2 + 1);
                                if (ch_rd[c]) m_ops.push_back(c * 2);
                            end
                        end
                        m_fetch = 0;
                    end
                end else if (m_waitc == TO - 1) begin
                    e_err   = 1;
                    m_waitc = 0;
                end else begin
                    m_waitc++;
                end
            end else begin
                op = m_ops[0];
                c  = op / 2;
                w  = (op % 2) == 1;
                chk("iren", iren, 0);
                chk("dren", dren, !w);
                chk("dwen", dwen, w);
                chk("daddr", daddr, ch_addr[c*32 +: 32]);
                if (w) chk("dstore", dstore, ch_wdata[c*32 +: 32]);
                if (dhit) begin
                    m_waitc = 0;
                    void'(m_ops.pop_front());
                    if (m_ops.size() == 0 || m_ops[0] / 2 != c) begin
                        e_done[c]   = 1;
                        m_served[c] = 1;
                        m_rr        = (c + 1) % NCH;
                        if (!w) chk("rdata", rdata, dload);
                        if (m_ops.size() == 0) begin
                            e_adv    = 1;
                            m_served = 0;
                            m_fetch  = 1;
                        end
                    end
                end else if (m_waitc == TO - 1) begin
                    e_err       = 1;
                    m_waitc     = 0;
                    m_served[c] = 1;
                    m_ops.delete();
                    m_fetch     = 1;
                end else begin
                    m_waitc++;
                end
            end
            chk("ch_done", ch_done, e_done);
            chk("adv", adv, e_adv);
            chk("err", err, e_err);
            if (e_adv) req_free = 1;
        end
    end

    initial begin
        rst = 1; pc = 32'h1000; ihit = 0; instr = 0; ch_rd = 0; ch_wr = 0;
        ch_addr = 0; ch_wdata = 0; dhit = 0; dload = 0;
        repeat (2) @(negedge clk);
        chk("t0_iren", iren, 1); chk("t0_instr_q", instr_q, 0); chk("t0_adv", adv, 0);
        tick(); rst = 0;

        // No data requests: every ihit advances.
        for (int i = 0; i < 3; i++) begin
            ihit = 1; instr = 32'hA5A5_0001;
            @(negedge clk);
            chk("t1_adv", adv, 1); chk("t1_dren", dren, 0); chk("t1_dwen", dwen, 0);
            tick(); ihit = 0; instr = 0;
            @(negedge clk);
            chk("t1_instr_q", instr_q, 32'hA5A5_0001); chk("t1_adv_idle", adv, 0);
            tick();
        end

        // Two readers from rr_ptr=0.
        ch_rd = 2'b11; ch_addr = {32'h200, 32'h100}; ihit = 1;
        @(negedge clk); chk("t2_fetch_adv", adv, 0);
        tick(); ihit = 0;
        @(negedge clk); chk("t2_daddr0", daddr, 32'h100); chk("t2_dren0", dren, 1);
        chk("t2_wait_done", ch_done, 0);
        tick(); dhit = 1; dload = 32'h1111;
        @(negedge clk); chk("t2_done0", ch_done, 2'b01); chk("t2_rdata0", rdata, 32'h1111);
        chk("t2_adv0", adv, 0);
        tick(); dhit = 0;
        @(negedge clk); chk("t2_daddr1", daddr, 32'h200); chk("t2_dren1", dren, 1);
        tick(); dhit = 1; dload = 32'h2222;
        @(negedge clk); chk("t2_done1", ch_done, 2'b10); chk("t2_rdata1", rdata, 32'h2222);
        chk("t2_adv1", adv, 1);
        tick(); dhit = 0; ch_rd = 0;

        // Write-then-read on channel 0.
        ch_rd = 2'b01; ch_wr = 2'b01; ch_addr = {32'h0, 32'h40};
        ch_wdata = {32'h0, 32'hDEAD_BEEF}; ihit = 1;
        @(negedge clk);
        tick(); ihit = 0;
        @(negedge clk); chk("t3_dwen", dwen, 1); chk("t3_dstore", dstore, 32'hDEAD_BEEF);
        chk("t3_waddr", daddr, 32'h40);
        tick(); dhit = 1;
        @(negedge clk); chk("t3_wr_nodone", ch_done, 0); chk("t3_wr_noadv", adv, 0);
        tick(); dhit = 0;
        @(negedge clk); chk("t3_dren", dren, 1); chk("t3_dwen_off", dwen, 0);
        chk("t3_raddr", daddr, 32'h40);
        tick(); dhit = 1; dload = 32'h3333;
        @(negedge clk); chk("t3_done", ch_done, 2'b01); chk("t3_rdata", rdata, 32'h3333);
        chk("t3_adv", adv, 1);
        tick(); dhit = 0; ch_rd = 0; ch_wr = 0;

        // rr_ptr is now 1: channel 1 first.
        ch_rd = 2'b11; ch_addr = {32'h200, 32'h100}; ihit = 1;
        @(negedge clk);
        tick(); ihit = 0; dhit = 1;
        @(negedge clk); chk("t4_first", daddr, 32'h200); chk("t4_done1", ch_done, 2'b10);
        tick();
        @(negedge clk); chk("t4_second", daddr, 32'h100); chk("t4_done0", ch_done, 2'b01);
        chk("t4_adv", adv, 1);
        tick(); dhit = 0; ch_rd = 0;

        // Watchdog fires on the 8th wait cycle.
        ch_rd = 2'b01; ch_addr = {32'h0, 32'h40}; ihit = 1;
        @(negedge clk);
        tick(); ihit = 0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk); chk("t5_no_err", err, 0); chk("t5_dren", dren, 1);
            tick();
        end
        @(negedge clk); chk("t5_err", err, 1); chk("t5_err_noadv", adv, 0);
        chk("t5_err_nodone", ch_done, 0);
        tick();
        @(negedge clk); chk("t5_back_fetch", iren, 1); chk("t5_dren_off", dren, 0);
        tick(); ihit = 1;
        @(negedge clk); chk("t5_served_adv", adv, 1);
        tick();
        @(negedge clk); chk("t5_refetch_noadv", adv, 0);
        tick(); ihit = 0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk); chk("t5b_no_err", err, 0);
            tick();
        end
        dhit = 1; dload = 32'h4444;
        @(negedge clk); chk("t5b_hit_wins", err, 0); chk("t5b_done", ch_done, 2'b01);
        chk("t5b_adv", adv, 1);
        tick(); dhit = 0; ch_rd = 0;

        // Asynchronous reset while in DREAD.
        ch_rd = 2'b01; ch_addr = {32'h0, 32'h40}; ihit = 1; instr = 32'h1234_5678;
        @(negedge clk);
        tick(); ihit = 0; instr = 0;
        @(negedge clk); chk("t6_dren", dren, 1); chk("t6_instr_q", instr_q, 32'h1234_5678);
        @(posedge clk); #3; rst = 1; dhit = 1; dload = 32'h5555; #1;
        chk("t6_iren", iren, 1); chk("t6_dren_rst", dren, 0); chk("t6_done_rst", ch_done, 0);
        chk("t6_instr_q_rst", instr_q, 0); chk("t6_adv_rst", adv, 0);
        tick(); rst = 0; dhit = 0; ch_rd = 0; ihit = 1;
        @(negedge clk); chk("t6_adv_after", adv, 1);
        tick(); ihit = 0;

        // Random traffic; requests change only after a step completes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ihit  = 1'($urandom_range(0, 1));
            dhit  = ($urandom_range(0, 9) < 3);
            pc    = $urandom;
            instr = $urandom;
            dload = $urandom;
            if (req_free) begin
                ch_rd    = 2'($urandom_range(0, 3));
                ch_wr    = 2'($urandom_range(0, 3));
                ch_addr  = {$urandom, $urandom};
                ch_wdata = {$urandom, $urandom};
                req_free = 0;
            end
            rst = (cyc % 700 == 699);
            tick();
        end
        rst = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
